// File: rtl/bram_stream_reader.sv
// Streams a run of words out of a 256x16 block RAM onto a valid/ready port.
// Reads are throttled so the two-entry output FIFO can never overflow:
// buffered words plus the one possibly in flight in the BRAM never exceed two.
module bram_stream_reader (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_base,
    input  logic [8:0]  i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_rd_en,
    output logic [7:0]  o_raddr,
    input  logic [15:0] i_rdata,
    output logic        o_valid,
    output logic [15:0] o_data,
    input  logic        i_ready
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned LW = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t         state;
    logic [LW-1:0]  issue_left;
    logic [LW-1:0]  deliver_left;
    logic [1:0]     occ;
    logic           inflight;
    logic [DW-1:0]  tail;

    logic           pop_c;
    logic [2:0]     load_c;
    logic [1:0]     occ_next_c;

    // Pop handshake, FIFO load projection and read-issue decision
    always_comb begin
        pop_c      = o_valid & i_ready;
        load_c     = 3'(occ) + 3'(inflight) - 3'(pop_c);
        occ_next_c = occ + 2'(inflight) - 2'(pop_c);
        o_rd_en    = (state == RUN) && (issue_left != '0) && (load_c < 3'd2);
    end

    // Control FSM, address/length counters and the two-entry output FIFO
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_raddr      <= '0;
            o_valid      <= 1'b0;
            o_data       <= '0;
            tail         <= '0;
            occ          <= '0;
            inflight     <= 1'b0;
            issue_left   <= '0;
            deliver_left <= '0;
        end else begin
            o_done   <= 1'b0;
            inflight <= o_rd_en;
            occ      <= occ_next_c;
            o_valid  <= (occ_next_c != 2'd0);

            // o_data is the FIFO head, tail holds the second word
            if (inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop_c))) begin
                o_data <= i_rdata;
            end else if (inflight) begin
                tail <= i_rdata;
            end else if (pop_c && (occ == 2'd2)) begin
                o_data <= tail;
            end

            if (o_rd_en) begin
                o_raddr    <= o_raddr + AW'(1);
                issue_left <= issue_left - LW'(1);
            end

            if (pop_c) begin
                deliver_left <= deliver_left - LW'(1);
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        if (i_len != '0) begin
                            o_raddr      <= i_base;
                            issue_left   <= i_len;
                            deliver_left <= i_len;
                            o_busy       <= 1'b1;
                            state        <= RUN;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (o_rd_en && (issue_left == LW'(1))) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pop_c && (deliver_left == LW'(1))) begin
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader with a behavioural 256x16 BRAM.
module tb_bram_stream_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  base;
    logic [8:0]  len;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [7:0]  raddr;
    logic [15:0] rdata;
    logic        valid;
    logic [15:0] data;
    logic        ready;

    logic [15:0] mem [256];
    int          n_cmp;
    int          n_err;
    int          rd_cnt;

    bram_stream_reader dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_base  (base),
        .i_len   (len),
        .o_busy  (busy),
        .o_done  (done),
        .o_rd_en (rd_en),
        .o_raddr (raddr),
        .i_rdata (rdata),
        .o_valid (valid),
        .o_data  (data),
        .i_ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read block RAM model
    always @(posedge clk) begin
        if (rd_en) rdata <= mem[raddr];
    end

    // Count read requests once per cycle, after inputs have settled
    always @(negedge clk) begin
        #3;
        if (rd_en) rd_cnt = rd_cnt + 1;
    end

    typedef struct {
        logic        start;
        logic [7:0]  base;
        logic [8:0]  len;
        logic        ready;
        logic        busy;
        logic        done;
        logic        rd_en;
        logic [7:0]  raddr;
        logic        valid;
        logic [15:0] data;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " busy"},  32'(busy),  32'd0);
        chk({tag, " done"},  32'(done),  32'd0);
        chk({tag, " rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, " raddr"}, 32'(raddr), 32'd0);
        chk({tag, " valid"}, 32'(valid), 32'd0);
        chk({tag, " data"},  32'(data),  32'd0);
    endtask

    // Accept words until o_done, checking order, hold stability and read count
    task automatic drain(input logic [7:0] b, input int n, input bit toggle,
                         input bit spurious, input int rd_start, input string tag);
        int          idx;
        bit          rdy;
        bit          got;
        bit          held;
        logic [15:0] held_data;
        logic [7:0]  a;
        idx  = 0;
        rdy  = 1'b1;
        got  = 1'b0;
        held = 1'b0;
        held_data = '0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            ready = toggle ? rdy : 1'b1;
            rdy   = !rdy;
            if (spurious && c >= 2 && c <= 10) begin
                start = 1'b1;
                base  = 8'h33;
                len   = 9'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            if (held) begin
                chk({tag, " hold valid"}, 32'(valid), 32'd1);
                chk({tag, " hold data"}, 32'(data), 32'(held_data));
            end
            if (idx == n) begin
                chk({tag, " done after last"}, 32'(done), 32'd1);
                got = 1'b1;
            end else begin
                if (done) chk({tag, " early done"}, 32'(done), 32'd0);
                if (valid && ready) begin
                    a = b + 8'(idx);
                    chk({tag, " word"}, 32'(data), 32'(16'h1000 + 16'(a)));
                    idx = idx + 1;
                end
            end
            held      = valid && !ready;
            held_data = data;
        end
        start = 1'b0;
        if (!got) chk({tag, " timeout words"}, 32'(idx), 32'(n + 1));
        chk({tag, " read count"}, 32'(rd_cnt - rd_start), 32'(n));
    endtask

    initial begin
        int rd0;
        n_cmp  = 0;
        n_err  = 0;
        rd_cnt = 0;
        for (int k = 0; k < 256; k++) mem[k] = 16'h1000 + 16'(k);
        rdata = '0;
        rst_n = 1'b0;
        start = 1'b0;
        base  = '0;
        len   = '0;
        ready = 1'b1;

        //        start base   len    rdy busy done rd  raddr valid data
        tbl[0]  = '{1'b1, 8'h10, 9'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 16'h0000};
        tbl[3]  = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b1, 16'h1010};
        tbl[4]  = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h13, 1'b1, 16'h1011};
        tbl[5]  = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1012};
        tbl[6]  = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1013};
        tbl[7]  = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000};
        tbl[8]  = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
        tbl[9]  = '{1'b1, 8'h55, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
        tbl[10] = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000};
        tbl[11] = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
        tbl[12] = '{1'b1, 8'hFE, 9'd4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};
        tbl[13] = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b0, 16'h0000};
        tbl[14] = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 16'h0000};
        tbl[15] = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 16'h10FE};
        tbl[16] = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 16'h10FF};
        tbl[17] = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1000};
        tbl[18] = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1001};
        tbl[19] = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000};
        tbl[20] = '{1'b0, 8'h00, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000};

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        #1;
        check_reset("reset");

        // Table: basic transfer, zero-length start, address wrap
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i != 0) @(negedge clk);
            start = tbl[i].start;
            base  = tbl[i].base;
            len   = tbl[i].len;
            ready = tbl[i].ready;
            #1;
            chk($sformatf("vec%0d busy", i),  32'(busy),  32'(tbl[i].busy));
            chk($sformatf("vec%0d done", i),  32'(done),  32'(tbl[i].done));
            chk($sformatf("vec%0d rd_en", i), 32'(rd_en), 32'(tbl[i].rd_en));
            chk($sformatf("vec%0d valid", i), 32'(valid), 32'(tbl[i].valid));
            if (tbl[i].rd_en) chk($sformatf("vec%0d raddr", i), 32'(raddr), 32'(tbl[i].raddr));
            if (tbl[i].valid) chk($sformatf("vec%0d data", i), 32'(data), 32'(tbl[i].data));
        end
        start = 1'b0;

        // Backpressure: ready low for cycles 0-9, then drain 8 words
        @(negedge clk);
        rd0   = rd_cnt;
        start = 1'b1;
        base  = 8'h00;
        len   = 9'd8;
        ready = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (c >= 3) begin
                chk($sformatf("stall c%0d valid", c), 32'(valid), 32'd1);
                chk($sformatf("stall c%0d data", c), 32'(data), 32'h1000);
            end
        end
        #4;
        chk("stall reads", 32'(rd_cnt - rd0), 32'd2);
        drain(8'h00, 8, 1'b0, 1'b0, rd0, "stall");

        // Full 256-word transfer, ready toggling, spurious starts while busy
        @(negedge clk);
        rd0   = rd_cnt;
        start = 1'b1;
        base  = 8'h80;
        len   = 9'd256;
        ready = 1'b1;
        drain(8'h80, 256, 1'b1, 1'b1, rd0, "full");

        // Reset in the middle of a 16-word transfer
        @(negedge clk);
        start = 1'b1;
        base  = 8'h40;
        len   = 9'd16;
        ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midreset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("midreset c%0d done", c), 32'(done), 32'd0);
            chk($sformatf("midreset c%0d valid", c), 32'(valid), 32'd0);
        end

        // Start accepted on the first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        rd0   = rd_cnt;
        start = 1'b1;
        base  = 8'h20;
        len   = 9'd2;
        #1;
        chk("after reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("after reset rd_en", 32'(rd_en), 32'd1);
        chk("after reset raddr", 32'(raddr), 32'h20);
        drain(8'h20, 2, 1'b0, 1'b0, rd0, "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have exactly one clock and one reset: asynchronous, active-low. No parameters; address 8 bits, data 16 bits, fixed to match the 256x16 block RAM.
REQ-002 i_clk  input  1  sole clock; every register updates on its rising edge, and the attached BRAM read clock is tied to it.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_start  input  1  start request; sampled only in IDLE.
REQ-005 i_base  input  8  first BRAM address of the transfer; sampled with i_start.
REQ-006 i_len  input  9  word count, 0..256; sampled with i_start.
REQ-007 o_busy  output  1  transfer in progress.
REQ-008 o_done  output  1  one-cycle pulse when the transfer completes.
REQ-009 o_rd_en  output  1  BRAM read request; drives both read clock-enable and read-enable.
REQ-010 o_raddr  output  8  BRAM read address.
REQ-011 i_rdata  input  16  BRAM read data; valid in the cycle after o_rd_en was high.
REQ-012 o_valid  output  1  output stream word available.
REQ-013 o_data  output  16  output stream word.
REQ-014 i_ready  input  1  downstream accept; a word transfers on any cycle where o_valid and i_ready are both high.

Function
REQ-015 States SHALL be IDLE, RUN and FLUSH, held in a registered state variable.
REQ-016 IDLE with i_start=1 and i_len!=0 SHALL:
- latch i_base into the address counter;
- latch i_len into the remaining-to-issue and remaining-to-deliver counters;
- go to RUN.
REQ-017 IDLE with i_start=1 and i_len=0 SHALL pulse o_done in the next cycle, issue no reads and stay in IDLE.
REQ-018 i_start SHALL be ignored outside IDLE.
REQ-019 o_busy SHALL be 1 in RUN and FLUSH and 0 in IDLE.
REQ-020 Output buffering SHALL be a 2-entry FIFO holding registered BRAM data; o_valid=1 exactly when the FIFO is non-empty, and o_data is the FIFO head.
REQ-021 An in-flight flag SHALL be set in cycle n+1 whenever o_rd_en=1 in cycle n.
REQ-022 In the cycle after o_rd_en=1, the BRAM data (i_rdata) SHALL be written into the FIFO.
REQ-023 In RUN, o_rd_en SHALL be 1 exactly when both hold (combinational from state, counters and pop):
- remaining-to-issue != 0;
- occupancy + inflight - pop < 2, where pop = o_valid & i_ready.
REQ-024 Each issued read SHALL increment o_raddr modulo 256 (0xFF wraps to 0x00) and decrement remaining-to-issue.
REQ-025 When remaining-to-issue reaches 0, the state SHALL go to FLUSH.
REQ-026 Each accepted word SHALL decrement remaining-to-deliver.
REQ-027 When the final word is accepted, the block SHALL enter IDLE at that edge and pulse o_done for the following cycle.
REQ-028 Latency: i_start accepted at edge of cycle 0 -> o_rd_en=1 with o_raddr=base in cycle 1 -> o_valid=1 with o_data=mem[base] in cycle 3.
REQ-029 With i_ready held at 1, throughput SHALL be one word per cycle, and o_valid SHALL stay continuously high from the first word to the last.
REQ-030 With i_ready=0, o_valid and o_data SHALL hold stable; at most 2 words may be buffered, and o_rd_en stays 0 while occupancy + inflight = 2.
REQ-031 A simultaneous FIFO write and pop SHALL leave occupancy unchanged and preserve word order.
REQ-032 Words SHALL be emitted in ascending address order, with no loss or duplication.
REQ-033 Exactly len reads SHALL be issued per transfer.

Reset
REQ-034 While i_rst_n=0, the following SHALL be forced immediately, independent of i_clk:
- state=IDLE;
- o_busy=0, o_done=0, o_rd_en=0, o_raddr=0x00, o_valid=0, o_data=0x0000;
- FIFO empty, in-flight flag clear, all counters 0.
REQ-035 Reset asserted mid-transfer SHALL abandon the transfer: no o_done, and buffered words are discarded.
REQ-036 After reset release, the first i_start SHALL be accepted on the first rising edge at which i_rst_n=1.

Verification
REQ-037 Preload mem[k]=0x1000+k; start base=0x10, len=4, i_ready=1 -> o_rd_en cycles 1-4 at addresses 0x10-0x13; o_valid cycles 3-6 with data 0x1010-0x1013; o_done pulses in cycle 7.
REQ-038 base=0xFE, len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01 are read; data 0x10FE, 0x10FF, 0x1000, 0x1001 is emitted.
REQ-039 base=0x00, len=8, i_ready=0 for cycles 0-9 then 1 -> exactly 2 reads are issued before stall; o_data=0x1000 is held stable; all 8 words arrive in order; o_done follows the 8th accept.
REQ-040 i_ready toggling 1/0 every cycle, len=256 -> 256 words in order with wrap back to the base address; exactly 256 o_rd_en pulses.
REQ-041 len=0 start -> o_done pulses in cycle 1; o_rd_en, o_valid and o_busy stay 0; a second i_start asserted during a running transfer is ignored.
REQ-042 i_rst_n pulled low in the middle of a len=16 transfer -> all outputs reach their reset values immediately with no o_done; a subsequent transfer of base=0x20, len=2 yields 0x1020, 0x1021.
